// File: rtl/ticket_arbiter.sv
// ticket_arbiter: round-robin arbiter that shares one ticket counter among
// NUM_REQ requesters. The winner is shown the current count as its ticket,
// and the count advances when the winner acknowledges.
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   req_i[NUM_REQ]      level requests, sampled only while idle
//   ack_i               winner accepts the presented ticket
//   clr_i               pulse: restore count, zero issued, leave lockout
//   grant_o[NUM_REQ]    registered one-hot grant
//   ticket_valid_o      a ticket is presented (|grant_o)
//   ticket_o[WIDTH]     presented ticket value
//   issued_o[WIDTH+1]   tickets issued since reset/clear
//   exhausted_o         LIMIT tickets issued; no grants until cleared
module ticket_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int WIDTH      = 8,
    parameter int INIT_VALUE = 120,
    parameter int LIMIT      = 200
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               ack_i,
    input  logic               clr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic               ticket_valid_o,
    output logic [WIDTH-1:0]   ticket_o,
    output logic [WIDTH:0]     issued_o,
    output logic               exhausted_o
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_EXH   = 2'd2;

    localparam logic [WIDTH-1:0] INIT_V  = WIDTH'(INIT_VALUE);
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
    localparam logic [WIDTH:0]   ISS_ONE = (WIDTH+1)'(1);
    localparam logic [WIDTH:0]   LIMIT_V = (WIDTH+1)'(LIMIT);
    localparam logic [NUM_REQ-1:0] OH_ONE = NUM_REQ'(1);

    logic [1:0]         state_q,  state_d;
    logic [NUM_REQ-1:0] grant_q,  grant_d;
    logic [WIDTH-1:0]   ticket_q, ticket_d;
    logic [WIDTH-1:0]   count_q,  count_d;
    logic [WIDTH:0]     issued_q, issued_d;
    logic [PW-1:0]      ptr_q,    ptr_d;
    logic [PW-1:0]      win_q,    win_d;
    logic               pend_q,   pend_d;

    logic [PW-1:0]      arb_idx;
    logic [PW-1:0]      scan_idx;
    logic               arb_hit;
    logic               clr_now;
    logic [WIDTH:0]     issued_inc;

    // Scan downward so the last hit written is the one closest to ptr_q.
    always_comb begin
        arb_idx  = '0;
        arb_hit  = 1'b0;
        scan_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            scan_idx = PW'((int'(ptr_q) + i) % NUM_REQ);
            if (req_i[scan_idx]) begin
                arb_idx = scan_idx;
                arb_hit = 1'b1;
            end
        end
    end

    assign issued_inc = issued_q + ISS_ONE;
    // A clear seen during the grant is folded into the closing cycle.
    assign clr_now    = clr_i | pend_q;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        ticket_d = ticket_q;
        count_d  = count_q;
        issued_d = issued_q;
        ptr_d    = ptr_q;
        win_d    = win_q;
        pend_d   = pend_q;
        case (state_q)
            S_IDLE: begin
                if (clr_i) begin
                    count_d  = INIT_V;
                    issued_d = '0;
                end else if (arb_hit) begin
                    state_d  = S_GRANT;
                    grant_d  = OH_ONE << arb_idx;
                    ticket_d = count_q;
                    win_d    = arb_idx;
                end
            end
            S_GRANT: begin
                if (ack_i || !req_i[win_q]) begin
                    state_d  = S_IDLE;
                    grant_d  = '0;
                    ticket_d = '0;
                    pend_d   = 1'b0;
                    if (ack_i) begin
                        ptr_d = PW'((int'(win_q) + 1) % NUM_REQ);
                    end
                    if (clr_now) begin
                        count_d  = INIT_V;
                        issued_d = '0;
                    end else if (ack_i) begin
                        count_d  = count_q + CNT_ONE;
                        issued_d = issued_inc;
                        if (issued_inc == LIMIT_V) begin
                            state_d = S_EXH;
                        end
                    end
                end else if (clr_i) begin
                    pend_d = 1'b1;
                end
            end
            S_EXH: begin
                if (clr_i) begin
                    state_d  = S_IDLE;
                    count_d  = INIT_V;
                    issued_d = '0;
                end
            end
            default: begin
                state_d  = S_IDLE;
                grant_d  = '0;
                ticket_d = '0;
                pend_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            grant_q  <= '0;
            ticket_q <= '0;
            count_q  <= INIT_V;
            issued_q <= '0;
            ptr_q    <= '0;
            win_q    <= '0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            ticket_q <= ticket_d;
            count_q  <= count_d;
            issued_q <= issued_d;
            ptr_q    <= ptr_d;
            win_q    <= win_d;
            pend_q   <= pend_d;
        end
    end

    assign grant_o        = grant_q;
    assign ticket_valid_o = |grant_q;
    assign ticket_o       = ticket_q;
    assign issued_o       = issued_q;
    assign exhausted_o    = (state_q == S_EXH);

endmodule

// File: tb/tb_ticket_arbiter.sv
// tb_ticket_arbiter: bench for ticket_arbiter with three parameter sets
// (default, LIMIT=3, INIT_VALUE=254) and a transaction-level model.
module tb_ticket_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic       rst_a, ack_a, clr_a, tv_a, exh_a;
    logic [3:0] req_a, grant_a;
    logic [7:0] ticket_a;
    logic [8:0] issued_a;

    logic       rst_b, ack_b, clr_b, tv_b, exh_b;
    logic [3:0] req_b, grant_b;
    logic [7:0] ticket_b;
    logic [8:0] issued_b;

    logic       rst_c, ack_c, clr_c, tv_c, exh_c;
    logic [3:0] req_c, grant_c;
    logic [7:0] ticket_c;
    logic [8:0] issued_c;

    ticket_arbiter #(.NUM_REQ(4), .WIDTH(8),
                     .INIT_VALUE(120), .LIMIT(200)) dut_a (
        .clk(clk), .reset(rst_a), .req_i(req_a), .ack_i(ack_a),
        .clr_i(clr_a), .grant_o(grant_a), .ticket_valid_o(tv_a),
        .ticket_o(ticket_a), .issued_o(issued_a), .exhausted_o(exh_a));

    ticket_arbiter #(.NUM_REQ(4), .WIDTH(8),
                     .INIT_VALUE(120), .LIMIT(3)) dut_b (
        .clk(clk), .reset(rst_b), .req_i(req_b), .ack_i(ack_b),
        .clr_i(clr_b), .grant_o(grant_b), .ticket_valid_o(tv_b),
        .ticket_o(ticket_b), .issued_o(issued_b), .exhausted_o(exh_b));

    ticket_arbiter #(.NUM_REQ(4), .WIDTH(8),
                     .INIT_VALUE(254), .LIMIT(200)) dut_c (
        .clk(clk), .reset(rst_c), .req_i(req_c), .ack_i(ack_c),
        .clr_i(clr_c), .grant_o(grant_c), .ticket_valid_o(tv_c),
        .ticket_o(ticket_c), .issued_o(issued_c), .exhausted_o(exh_c));

    // Reference state for dut_a: next ticket, tickets issued, RR start.
    int m_count, m_issued, m_ptr;

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            int j;
            j = (p + k) % 4;
            if (r[j]) return j;
        end
        return 0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_a();
        rst_a = 1'b1; req_a = '0; ack_a = 1'b0; clr_a = 1'b0;
        step();
        rst_a = 1'b0;
        m_count = 120; m_issued = 0; m_ptr = 0;
    endtask

    task automatic test_reset();
        reset_a();
        checks++;
        if (grant_a !== 4'b0) begin
            failures++;
            $display("FAIL rst_grant got=%b exp=0000", grant_a);
        end
        checks++;
        if (tv_a !== 1'b0) begin
            failures++;
            $display("FAIL rst_valid got=%b exp=0", tv_a);
        end
        checks++;
        if (ticket_a !== 8'd0) begin
            failures++;
            $display("FAIL rst_ticket got=%0d exp=0", ticket_a);
        end
        checks++;
        if (issued_a !== 9'd0) begin
            failures++;
            $display("FAIL rst_issued got=%0d exp=0", issued_a);
        end
        checks++;
        if (exh_a !== 1'b0) begin
            failures++;
            $display("FAIL rst_exh got=%b exp=0", exh_a);
        end
    endtask

    // One complete transaction on dut_a: request, optional hold with
    // non-winner churn, then ack or withdrawal.
    task automatic txn_a(input logic [3:0] r, input bit do_ack,
                         input int hold);
        int w;
        logic [3:0] g;
        w = pick(r, m_ptr);
        g = 4'b0001 << w;
        req_a = r;
        step();
        checks++;
        if (grant_a !== g || tv_a !== 1'b1) begin
            failures++;
            $display("FAIL txn_grant got=%b/%b exp=%b/1",
                     grant_a, tv_a, g);
        end
        checks++;
        if (ticket_a !== 8'(m_count)) begin
            failures++;
            $display("FAIL txn_ticket got=%0d exp=%0d",
                     ticket_a, m_count);
        end
        for (int h = 0; h < hold; h++) begin
            req_a = 4'($urandom_range(0, 15)) | g;
            step();
            checks++;
            if (grant_a !== g || ticket_a !== 8'(m_count)) begin
                failures++;
                $display("FAIL txn_hold got=%b/%0d exp=%b/%0d",
                         grant_a, ticket_a, g, m_count);
            end
        end
        if (do_ack) begin
            ack_a = 1'b1;
            req_a = 4'($urandom_range(0, 15));
        end else begin
            req_a = 4'($urandom_range(0, 15)) & ~g;
        end
        step();
        ack_a = 1'b0;
        if (do_ack) begin
            m_count = (m_count + 1) % 256;
            m_issued++;
            m_ptr = (w + 1) % 4;
        end
        checks++;
        if (grant_a !== 4'b0 || issued_a !== 9'(m_issued)) begin
            failures++;
            $display("FAIL txn_end got=%b/%0d exp=0000/%0d",
                     grant_a, issued_a, m_issued);
        end
    endtask

    task automatic test_single();
        reset_a();
        txn_a(4'b0001, 1'b1, 0);
        txn_a(4'b0001, 1'b1, 0);
        req_a = '0;
    endtask

    task automatic test_round_robin();
        reset_a();
        req_a = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            int w;
            w = pick(4'b1111, m_ptr);
            step();
            checks++;
            if (grant_a !== (4'b0001 << w) ||
                ticket_a !== 8'(120 + k)) begin
                failures++;
                $display("FAIL rr_%0d got=%b/%0d exp=%b/%0d", k,
                         grant_a, ticket_a, 4'b0001 << w, 120 + k);
            end
            ack_a = 1'b1;
            step();
            ack_a = 1'b0;
            m_count++; m_issued++; m_ptr = (w + 1) % 4;
            checks++;
            if (grant_a !== 4'b0) begin
                failures++;
                $display("FAIL rr_gap_%0d got=%b exp=0000", k, grant_a);
            end
        end
        req_a = '0;
        step();
    endtask

    task automatic test_withdraw();
        reset_a();
        txn_a(4'b0010, 1'b0, 1);
        txn_a(4'b0010, 1'b1, 0);
        req_a = '0;
        step();
    endtask

    task automatic test_random();
        reset_a();
        for (int n = 0; n < 40; n++) begin
            logic [3:0] r;
            r = 4'($urandom_range(1, 15));
            txn_a(r, 1'($urandom_range(0, 3) != 0),
                  int'($urandom_range(0, 2)));
        end
        req_a = '0;
        step();
    endtask

    task automatic test_clr();
        reset_a();
        txn_a(4'b0001, 1'b1, 0);
        req_a = 4'b0001;
        clr_a = 1'b1;
        step();
        clr_a = 1'b0;
        checks++;
        if (grant_a !== 4'b0 || issued_a !== 9'd0) begin
            failures++;
            $display("FAIL clr_idle got=%b/%0d exp=0000/0",
                     grant_a, issued_a);
        end
        m_count = 120; m_issued = 0;
        req_a = '0;
        step();
        txn_a(4'b0001, 1'b1, 0);
        req_a = 4'b0100;
        step();
        checks++;
        if (grant_a !== 4'b0100 || ticket_a !== 8'd121) begin
            failures++;
            $display("FAIL clr_pre got=%b/%0d exp=0100/121",
                     grant_a, ticket_a);
        end
        clr_a = 1'b1;
        step();
        clr_a = 1'b0;
        checks++;
        if (grant_a !== 4'b0100 || ticket_a !== 8'd121) begin
            failures++;
            $display("FAIL clr_hold got=%b/%0d exp=0100/121",
                     grant_a, ticket_a);
        end
        ack_a = 1'b1;
        step();
        ack_a = 1'b0;
        req_a = '0;
        m_count = 120; m_issued = 0; m_ptr = 3;
        checks++;
        if (grant_a !== 4'b0 || issued_a !== 9'd0) begin
            failures++;
            $display("FAIL clr_ack got=%b/%0d exp=0000/0",
                     grant_a, issued_a);
        end
        txn_a(4'b0100, 1'b1, 0);
        req_a = '0;
        step();
    endtask

    task automatic test_reset_mid_grant();
        reset_a();
        txn_a(4'b1000, 1'b1, 0);
        req_a = 4'b0001;
        step();
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        checks++;
        if (grant_a !== 4'b0 || tv_a !== 1'b0 || ticket_a !== 8'd0 ||
            issued_a !== 9'd0 || exh_a !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid got=%b/%b/%0d/%0d/%b exp=0",
                     grant_a, tv_a, ticket_a, issued_a, exh_a);
        end
        m_count = 120; m_issued = 0; m_ptr = 0;
        txn_a(4'b0001, 1'b1, 0);
        req_a = '0;
    endtask

    task automatic test_limit();
        rst_b = 1'b1; req_b = '0; ack_b = 1'b0; clr_b = 1'b0;
        step();
        rst_b = 1'b0;
        req_b = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (grant_b !== (4'b0001 << k) ||
                ticket_b !== 8'(120 + k)) begin
                failures++;
                $display("FAIL lim_%0d got=%b/%0d exp=%b/%0d", k,
                         grant_b, ticket_b, 4'b0001 << k, 120 + k);
            end
            ack_b = 1'b1;
            step();
            ack_b = 1'b0;
        end
        checks++;
        if (exh_b !== 1'b1 || issued_b !== 9'd3) begin
            failures++;
            $display("FAIL lim_exh got=%b/%0d exp=1/3",
                     exh_b, issued_b);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (grant_b !== 4'b0 || exh_b !== 1'b1) begin
                failures++;
                $display("FAIL lim_lock got=%b/%b exp=0000/1",
                         grant_b, exh_b);
            end
        end
        clr_b = 1'b1;
        step();
        clr_b = 1'b0;
        checks++;
        if (exh_b !== 1'b0 || issued_b !== 9'd0 ||
            grant_b !== 4'b0) begin
            failures++;
            $display("FAIL lim_clr got=%b/%0d/%b exp=0/0/0000",
                     exh_b, issued_b, grant_b);
        end
        step();
        checks++;
        if (grant_b !== 4'b1000 || ticket_b !== 8'd120) begin
            failures++;
            $display("FAIL lim_after got=%b/%0d exp=1000/120",
                     grant_b, ticket_b);
        end
        req_b = '0;
        ack_b = 1'b1;
        step();
        ack_b = 1'b0;
    endtask

    task automatic test_wrap();
        rst_c = 1'b1; req_c = '0; ack_c = 1'b0; clr_c = 1'b0;
        step();
        rst_c = 1'b0;
        req_c = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (ticket_c !== 8'((254 + k) % 256) || tv_c !== 1'b1) begin
                failures++;
                $display("FAIL wrap_%0d got=%0d/%b exp=%0d/1", k,
                         ticket_c, tv_c, (254 + k) % 256);
            end
            ack_c = 1'b1;
            step();
            ack_c = 1'b0;
            if (k == 2) begin
                checks++;
                if (issued_c !== 9'd3 || exh_c !== 1'b0) begin
                    failures++;
                    $display("FAIL wrap_iss got=%0d/%b exp=3/0",
                             issued_c, exh_c);
                end
            end
        end
        req_c = '0;
    endtask

    initial begin
        rst_a = 1'b1; req_a = '0; ack_a = 1'b0; clr_a = 1'b0;
        rst_b = 1'b1; req_b = '0; ack_b = 1'b0; clr_b = 1'b0;
        rst_c = 1'b1; req_c = '0; ack_c = 1'b0; clr_c = 1'b0;
        m_count = 120; m_issued = 0; m_ptr = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_withdraw();
        test_clr();
        test_reset_mid_grant();
        test_random();
        test_limit();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
